// File: rtl/quad_pkg.sv
// Shared types, Gray-code phase constants and transition classifier for the
// quadrature decoder.
package quad_pkg;

    typedef logic [1:0] quad_phase_t;

    typedef enum logic {QD_INIT, QD_TRACK} quad_fsm_t;

    typedef enum logic [1:0] {QD_NONE, QD_UP, QD_DOWN, QD_ILLEGAL} quad_dir_t;

    localparam quad_phase_t QD_S00 = 2'b00;
    localparam quad_phase_t QD_S10 = 2'b10;
    localparam quad_phase_t QD_S11 = 2'b11;
    localparam quad_phase_t QD_S01 = 2'b01;

    // Successor of a phase in the counting-up direction: 00 -> 10 -> 11 -> 01 -> 00.
    function automatic quad_phase_t quad_next_up(input quad_phase_t s);
        quad_phase_t n;
        case (s)
            QD_S00:  n = QD_S10;
            QD_S10:  n = QD_S11;
            QD_S11:  n = QD_S01;
            default: n = QD_S00;
        endcase
        return n;
    endfunction

    function automatic quad_dir_t quad_dir(input quad_phase_t old_s, input quad_phase_t new_s);
        quad_dir_t d;
        if (new_s == old_s)                    d = QD_NONE;
        else if (new_s == quad_next_up(old_s)) d = QD_UP;
        else if (old_s == quad_next_up(new_s)) d = QD_DOWN;
        else                                   d = QD_ILLEGAL;
        return d;
    endfunction

endpackage

// File: rtl/quad_input_filter.sv
// Synchronises the two encoder phases and accepts a new phase value only after
// it has been stable for FILTER_LEN consecutive clocks.
module quad_input_filter
    import quad_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        track,
    input  logic        a_in,
    input  logic        b_in,
    output quad_phase_t sync_state,
    output quad_phase_t acc_state,
    output logic        accept
);

    localparam int CNT_W = $clog2(FILTER_LEN + 1);

    logic [SYNC_STAGES-1:0] a_sync;
    logic [SYNC_STAGES-1:0] b_sync;
    quad_phase_t            cand_q, cand_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [CNT_W-1:0]       run_len;

    assign sync_state = {a_sync[SYNC_STAGES-1], b_sync[SYNC_STAGES-1]};

    // Before the first acceptance there is no meaningful accepted state, so any
    // stable value (including 00) qualifies.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        cand_d  = cand_q;
        count_d = count_q;
        run_len = '0;
        accept  = 1'b0;
        if (track && sync_state == acc_state) begin
            count_d = '0;
        end else begin
            cand_d  = sync_state;
            run_len = (sync_state == cand_q) ? count_q + CNT_W'(1) : CNT_W'(1);
            if (run_len >= CNT_W'(FILTER_LEN)) begin
                accept  = 1'b1;
                count_d = '0;
            end else begin
                count_d = run_len;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sync    <= '0;
            b_sync    <= '0;
            cand_q    <= QD_S00;
            count_q   <= '0;
            acc_state <= QD_S00;
        end else begin
            a_sync  <= {a_sync[SYNC_STAGES-2:0], a_in};
            b_sync  <= {b_sync[SYNC_STAGES-2:0], b_in};
            cand_q  <= cand_d;
            count_q <= count_d;
            if (accept) acc_state <= sync_state;
        end
    end

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: filtered A/B phases drive an INIT/TRACK FSM that emits
// step/direction pulses, illegal-transition errors and a wrapping position.
module quad_decoder
    import quad_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             clr,
    input  logic             a_in,
    input  logic             b_in,
    output logic             step,
    output logic             up_down,
    output logic             err,
    output logic [WIDTH-1:0] pos
);

    quad_fsm_t        fsm_q, fsm_d;
    quad_phase_t      sync_state;
    quad_phase_t      acc_state;
    quad_dir_t        dir;
    logic             accept;
    logic             step_d, err_d, up_down_d;
    logic [WIDTH-1:0] pos_d;

    quad_input_filter #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILTER_LEN (FILTER_LEN)
    ) u_filter (
        .clk       (clk),
        .rst       (rst),
        .track     (fsm_q == QD_TRACK),
        .a_in      (a_in),
        .b_in      (b_in),
        .sync_state(sync_state),
        .acc_state (acc_state),
        .accept    (accept)
    );

    assign dir = quad_dir(acc_state, sync_state);

    // Outputs are registered on the same edge that the filter accepts the new phase.
    always_comb begin
        fsm_d     = fsm_q;
        step_d    = 1'b0;
        err_d     = 1'b0;
        up_down_d = up_down;
        pos_d     = pos;
        if (accept) begin
            if (fsm_q == QD_INIT) begin
                fsm_d = QD_TRACK;
            end else if (enable) begin
                case (dir)
                    QD_UP: begin
                        step_d    = 1'b1;
                        up_down_d = 1'b1;
                        pos_d     = pos + WIDTH'(1);
                    end
                    QD_DOWN: begin
                        step_d    = 1'b1;
                        up_down_d = 1'b0;
                        pos_d     = pos - WIDTH'(1);
                    end
                    QD_ILLEGAL: err_d = 1'b1;
                    default: ;
                endcase
            end
        end
        if (clr) pos_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q   <= QD_INIT;
            step    <= 1'b0;
            err     <= 1'b0;
            up_down <= 1'b1;
            pos     <= '0;
        end else begin
            fsm_q   <= fsm_d;
            step    <= step_d;
            err     <= err_d;
            up_down <= up_down_d;
            pos     <= pos_d;
        end
    end

endmodule
